// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 captures operands, stage 2 holds the result and status flags.
// Valid/ready handshakes on both sides; cflag carries arithmetic carry between consecutive ops.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             use_cflag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             compare
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [3:0]       s1_sel_q;
    logic             s1_mode_q, s1_cin_q, s1_use_cflag_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             carry_q, overflow_q, zero_q, negative_q, compare_q;
    logic             cflag_q;

    logic adv2, accept, xfer;

    assign adv2     = !s2_valid_q || out_ready;
    assign in_ready = (!s1_valid_q || adv2) && !flush;
    assign accept   = in_valid && in_ready;
    assign xfer     = s1_valid_q && adv2 && !flush;

    logic [WIDTH-1:0] x, y, f_logic, f_next;
    logic [WIDTH:0]   sum;
    logic             c, co_next, ov_next;

    always_comb begin
        f_logic = '0;
        x       = '0;
        y       = '0;
        unique case (s1_sel_q)
            4'h0: f_logic = ~s1_a_q;
            4'h1: f_logic = ~(s1_a_q | s1_b_q);
            4'h2: f_logic = ~s1_a_q & s1_b_q;
            4'h3: f_logic = '0;
            4'h4: f_logic = ~(s1_a_q & s1_b_q);
            4'h5: f_logic = ~s1_b_q;
            4'h6: f_logic = s1_a_q ^ s1_b_q;
            4'h7: f_logic = s1_a_q & ~s1_b_q;
            4'h8: f_logic = ~s1_a_q | s1_b_q;
            4'h9: f_logic = ~(s1_a_q ^ s1_b_q);
            4'hA: f_logic = s1_b_q;
            4'hB: f_logic = s1_a_q & s1_b_q;
            4'hC: f_logic = '1;
            4'hD: f_logic = s1_a_q | ~s1_b_q;
            4'hE: f_logic = s1_a_q | s1_b_q;
            4'hF: f_logic = s1_a_q;
        endcase
        unique case (s1_sel_q)
            4'h0: begin x = s1_a_q;             y = '0;                end
            4'h1: begin x = s1_a_q | s1_b_q;    y = '0;                end
            4'h2: begin x = s1_a_q | ~s1_b_q;   y = '0;                end
            4'h3: begin x = '0;                 y = '1;                end
            4'h4: begin x = s1_a_q;             y = s1_a_q & ~s1_b_q;  end
            4'h5: begin x = s1_a_q | s1_b_q;    y = s1_a_q & ~s1_b_q;  end
            4'h6: begin x = s1_a_q;             y = ~s1_b_q;           end
            4'h7: begin x = s1_a_q & ~s1_b_q;   y = '1;                end
            4'h8: begin x = s1_a_q;             y = s1_a_q & s1_b_q;   end
            4'h9: begin x = s1_a_q;             y = s1_b_q;            end
            4'hA: begin x = s1_a_q | ~s1_b_q;   y = s1_a_q & s1_b_q;   end
            4'hB: begin x = s1_a_q & s1_b_q;    y = '1;                end
            4'hC: begin x = s1_a_q;             y = s1_a_q;            end
            4'hD: begin x = s1_a_q | s1_b_q;    y = s1_a_q;            end
            4'hE: begin x = s1_a_q | ~s1_b_q;   y = s1_a_q;            end
            4'hF: begin x = s1_a_q;             y = '1;                end
        endcase
        // Carry source is resolved here so a chained op sees the preceding op's cflag update.
        c   = s1_use_cflag_q ? cflag_q : s1_cin_q;
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        if (s1_mode_q) begin
            f_next  = f_logic;
            co_next = 1'b0;
            ov_next = 1'b0;
        end else begin
            f_next  = sum[WIDTH-1:0];
            co_next = sum[WIDTH];
            ov_next = (x[WIDTH-1] == y[WIDTH-1]) && (f_next[WIDTH-1] != x[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_sel_q       <= '0;
            s1_mode_q      <= 1'b0;
            s1_cin_q       <= 1'b0;
            s1_use_cflag_q <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (accept) begin
                s1_valid_q <= 1'b1;
            end else if (xfer) begin
                s1_valid_q <= 1'b0;
            end
            if (accept) begin
                s1_a_q         <= in_a;
                s1_b_q         <= in_b;
                s1_sel_q       <= select;
                s1_mode_q      <= mode;
                s1_cin_q       <= carry_in;
                s1_use_cflag_q <= use_cflag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            f_q        <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            compare_q  <= 1'b0;
            cflag_q    <= 1'b0;
        end else begin
            if (flush) begin
                s2_valid_q <= 1'b0;
            end else if (xfer) begin
                s2_valid_q <= 1'b1;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
            if (xfer) begin
                f_q        <= f_next;
                carry_q    <= co_next;
                overflow_q <= ov_next;
                zero_q     <= (f_next == '0);
                negative_q <= f_next[WIDTH-1];
                compare_q  <= (s1_a_q == s1_b_q);
                if (!s1_mode_q) begin
                    cflag_q <= co_next;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign alu_out   = f_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign compare   = compare_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases plus randomized traffic checked against a
// queue-based behavioural model of the pipeline.
module tb_alu_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [3:0]   select = '0;
    logic         mode = 1'b0, carry_in = 1'b0, use_cflag = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_out;
    logic         carry_out, overflow, zero, negative, compare;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .select    (select),
        .mode      (mode),
        .carry_in  (carry_in),
        .use_cflag (use_cflag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .compare   (compare)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] f;
        logic         co, ov, z, n, cmp;
    } res_t;

    res_t q[$];
    logic mcflag = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truth table per select, indexed by {a_bit, b_bit}.
    function automatic logic [3:0] logic_tt(input logic [3:0] sel);
        case (sel)
            4'h0: return 4'b0011;  4'h1: return 4'b0001;
            4'h2: return 4'b0010;  4'h3: return 4'b0000;
            4'h4: return 4'b0111;  4'h5: return 4'b0101;
            4'h6: return 4'b0110;  4'h7: return 4'b0100;
            4'h8: return 4'b1011;  4'h9: return 4'b1001;
            4'hA: return 4'b1010;  4'hB: return 4'b1000;
            4'hC: return 4'b1111;  4'hD: return 4'b1101;
            4'hE: return 4'b1110;  default: return 4'b1100;
        endcase
    endfunction

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel, input logic md, input logic c);
        res_t         r;
        logic [3:0]   tt;
        logic [W-1:0] x, y, ones;
        int           s, sv;
        ones = '1;
        r = '0;
        if (md) begin
            tt = logic_tt(sel);
            for (int i = 0; i < W; i++) r.f[i] = tt[{a[i], b[i]}];
        end else begin
            case (sel)
                4'h0: begin x = a;      y = '0;     end
                4'h1: begin x = a | b;  y = '0;     end
                4'h2: begin x = a | ~b; y = '0;     end
                4'h3: begin x = '0;     y = ones;   end
                4'h4: begin x = a;      y = a & ~b; end
                4'h5: begin x = a | b;  y = a & ~b; end
                4'h6: begin x = a;      y = ~b;     end
                4'h7: begin x = a & ~b; y = ones;   end
                4'h8: begin x = a;      y = a & b;  end
                4'h9: begin x = a;      y = b;      end
                4'hA: begin x = a | ~b; y = a & b;  end
                4'hB: begin x = a & b;  y = ones;   end
                4'hC: begin x = a;      y = a;      end
                4'hD: begin x = a | b;  y = a;      end
                4'hE: begin x = a | ~b; y = a;      end
                default: begin x = a;   y = ones;   end
            endcase
            s    = int'(x) + int'(y) + int'(c);
            sv   = int'($signed(x)) + int'($signed(y)) + int'(c);
            r.f  = s[W-1:0];
            r.co = s[W];
            r.ov = (sv > 32767) || (sv < -32768);
        end
        r.z   = (r.f == '0);
        r.n   = r.f[W-1];
        r.cmp = (a == b);
        return r;
    endfunction

    // Compare process: checks every valid output against the model queue, then records accepts.
    always @(negedge clk) begin
        res_t e, r;
        if (!rst) begin
            q.delete();
            mcflag = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", out_valid, 1'b0);
                end else begin
                    e = q[0];
                    chk("mdl_f", alu_out, e.f);
                    chk("mdl_co", carry_out, e.co);
                    chk("mdl_ov", overflow, e.ov);
                    chk("mdl_z", zero, e.z);
                    chk("mdl_n", negative, e.n);
                    chk("mdl_cmp", compare, e.cmp);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                r = model(in_a, in_b, select, mode, use_cflag ? mcflag : carry_in);
                q.push_back(r);
                if (!mode) mcflag = r.co;
            end
            if (flush) q.delete();
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                        input logic md, input logic cin, input logic uc);
        in_a = a; in_b = b; select = sel; mode = md; carry_in = cin; use_cflag = uc;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] f, input logic co,
                              input logic ov, input logic z, input logic n, input logic cmp);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk({name, "_f"}, alu_out, f);
                chk({name, "_co"}, carry_out, co);
                chk({name, "_ov"}, overflow, ov);
                chk({name, "_z"}, zero, z);
                chk({name, "_n"}, negative, n);
                chk({name, "_cmp"}, compare, cmp);
                @(posedge clk); #1;
                return;
            end
        end
        chk({name, "_timeout"}, out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, acc;
        logic [W-1:0] snap;
        logic [W-1:0] got[3];

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_alu_out", alu_out, 16'h0000);
        chk("rst_flags", {carry_out, overflow, zero, negative, compare}, 5'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Latency and add with carry out.
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("lat_edge1", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_edge2", out_valid, 1'b1);
        chk("t1_f", alu_out, 16'h0000);
        chk("t1_co", carry_out, 1'b1);
        chk("t1_z", zero, 1'b1);
        chk("t1_ov", overflow, 1'b0);
        @(posedge clk); #1;

        send(16'h0005, 16'h0003, 4'h6, 1'b0, 1'b1, 1'b0);
        expect_out("sub", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        expect_out("ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Carry chaining back-to-back.
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 4'h9, 1'b0, 1'b0, 1'b1);
        chk("chain1_f", alu_out, 16'h0000);
        chk("chain1_co", carry_out, 1'b1);
        @(posedge clk); #1;
        chk("chain2_valid", out_valid, 1'b1);
        chk("chain2_f", alu_out, 16'h0001);
        chk("chain2_co", carry_out, 1'b0);
        @(posedge clk); #1;

        // Logic mode.
        send(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1, 1'b0);
        expect_out("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'hF0F0, 16'hFF00, 4'hC, 1'b1, 1'b0, 1'b0);
        expect_out("ones", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h1234, 16'h1234, 4'h6, 1'b1, 1'b0, 1'b0);
        expect_out("cmp", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Backpressure: three ops offered, two fit.
        out_ready = 1'b0;
        idx = 0;
        select = 4'h9; mode = 1'b0; carry_in = 1'b0; use_cflag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (idx < 3);
            in_a = 16'(idx + 1); in_b = 16'(idx + 1);
            @(negedge clk);
            acc = int'(in_valid && in_ready);
            @(posedge clk); #1;
            idx += acc;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_head", alu_out, 16'h0002);
        snap = alu_out;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_stable", alu_out, snap);
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = (idx < 3);
            in_a = 16'(idx + 1); in_b = 16'(idx + 1);
            @(negedge clk);
            if (out_valid && acc < 3) begin
                got[acc] = alu_out;
                acc++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_drain_count", acc, 3);
        chk("bp_order0", got[0], 16'h0002);
        chk("bp_order1", got[1], 16'h0004);
        chk("bp_order2", got[2], 16'h0006);

        // Async reset with both stages full clears cflag.
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        expect_out("pre_rst", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        send(16'h0003, 16'h0004, 4'h6, 1'b1, 1'b0, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_alu_out", alu_out, 16'h0000);
        chk("arst_co", carry_out, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        send(16'h0000, 16'h0000, 4'h9, 1'b0, 1'b0, 1'b1);
        expect_out("cflag_cleared", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Flush drops both beats and keeps cflag.
        send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
        expect_out("pre_flush", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 4'h6, 1'b1, 1'b0, 1'b0);
        send(16'h0005, 16'h0005, 4'h6, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1; in_a = 16'h00AA; select = 4'hF; mode = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("flush_empty", out_valid, 1'b0);
        send(16'h0000, 16'h0000, 4'h9, 1'b0, 1'b0, 1'b1);
        expect_out("cflag_kept", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_a      = 16'($urandom);
            in_b      = ($urandom_range(7) == 0) ? in_a : 16'($urandom);
            select    = 4'($urandom);
            mode      = 1'($urandom);
            carry_in  = 1'($urandom);
            use_cflag = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
